// File: rtl/plab2_mem_pipelined_resp_mem_pkg.sv
// Shared memory-message definitions: request type encodings, field widths and
// the response message layout used by processor control and the memory responder.
package plab2_mem_pipelined_resp_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic MEMREQ_TYPE_READ  = 1'b0;
    localparam logic MEMREQ_TYPE_WRITE = 1'b1;

    typedef struct packed {
        logic                  kind;
        logic [MEM_DATA_W-1:0] data;
    } mem_resp_msg_t;

    // Writes carry no data back; reads return the sampled word.
    function automatic mem_resp_msg_t make_resp(logic kind, logic [MEM_DATA_W-1:0] rd_data);
        mem_resp_msg_t r;
        r.kind = kind;
        r.data = (kind == MEMREQ_TYPE_WRITE) ? '0 : rd_data;
        return r;
    endfunction

endpackage

// File: rtl/plab2_mem_resp_queue.sv
// Circular response FIFO with val/rdy enqueue and dequeue sides and an occupancy count.
// Handshake: a side transfers in a cycle only when both its val and rdy are high.
module plab2_mem_resp_queue
    import plab2_mem_pipelined_resp_mem_pkg::*;
#(
    parameter int p_depth = 4,
    localparam int CW = $clog2(p_depth + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enq_val,
    output logic          enq_rdy,
    input  mem_resp_msg_t enq_msg,
    output logic          deq_val,
    input  logic          deq_rdy,
    output mem_resp_msg_t deq_msg,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(p_depth);

    mem_resp_msg_t slots [p_depth];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] bump(logic [PW-1:0] p);
        return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
    endfunction

    // A full queue refuses enqueue even when popping; the upstream credit check
    // guarantees that case never carries a valid entry.
    assign enq_rdy = count < CW'(p_depth);
    assign deq_val = count != '0;
    assign push    = enq_val && enq_rdy;
    assign pop     = deq_val && deq_rdy;
    assign deq_msg = slots[head];

    always_ff @(posedge clk) begin
        if (push) begin
            slots[tail] <= enq_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= bump(tail);
            end
            if (pop) begin
                head <= bump(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/plab2_mem_pipelined_resp_mem.sv
// Pipelined test memory: accepts one request per cycle, returns responses in order
// after p_latency cycles through a delay line feeding a credit-protected response FIFO.
module plab2_mem_pipelined_resp_mem
    import plab2_mem_pipelined_resp_mem_pkg::*;
#(
    parameter int p_mem_nwords = 256,
    parameter int p_latency    = 2,
    parameter int p_qdepth     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memreq_val,
    output logic                  memreq_rdy,
    input  logic                  memreq_type,
    input  logic [MEM_ADDR_W-1:0] memreq_addr,
    input  logic [MEM_DATA_W-1:0] memreq_data,
    output logic                  memresp_val,
    input  logic                  memresp_rdy,
    output logic                  memresp_type,
    output logic [MEM_DATA_W-1:0] memresp_data
);

    localparam int IW = $clog2(p_mem_nwords);
    localparam int CW = $clog2(p_qdepth + 1);

    logic [MEM_DATA_W-1:0] mem [p_mem_nwords];
    logic [IW-1:0]         idx;
    logic                  req_go;
    mem_resp_msg_t         new_msg;
    logic                  enq_val;
    logic                  enq_rdy;
    mem_resp_msg_t         enq_msg;
    logic                  deq_val;
    mem_resp_msg_t         deq_msg;
    logic [CW-1:0]         q_count;
    logic [CW-1:0]         inflight;
    logic [CW:0]           used;
    logic                  addr_unused;

    // Byte offset and high bits are dropped, so out-of-range addresses alias.
    assign idx         = memreq_addr[IW+1:2];
    assign addr_unused = ^{memreq_addr[MEM_ADDR_W-1:IW+2], memreq_addr[1:0]};

    assign req_go  = memreq_val && memreq_rdy;
    assign new_msg = make_resp(memreq_type, mem[idx]);

    // Array is deliberately not reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (req_go && memreq_type == MEMREQ_TYPE_WRITE) begin
            mem[idx] <= memreq_data;
        end
    end

    if (p_latency > 1) begin : g_delay
        localparam int NS = p_latency - 1;
        logic          dl_val [NS];
        mem_resp_msg_t dl_msg [NS];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < NS; i++) dl_val[i] <= 1'b0;
            end else begin
                dl_val[0] <= req_go;
                for (int i = 1; i < NS; i++) dl_val[i] <= dl_val[i-1];
            end
        end

        always_ff @(posedge clk) begin
            dl_msg[0] <= new_msg;
            for (int i = 1; i < NS; i++) dl_msg[i] <= dl_msg[i-1];
        end

        always_comb begin
            inflight = '0;
            for (int i = 0; i < NS; i++) inflight = inflight + CW'(dl_val[i]);
        end

        assign enq_val = dl_val[NS-1];
        assign enq_msg = dl_msg[NS-1];
    end else begin : g_direct
        assign enq_val  = req_go;
        assign enq_msg  = new_msg;
        assign inflight = '0;
    end

    plab2_mem_resp_queue #(.p_depth(p_qdepth)) resp_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (enq_val),
        .enq_rdy (enq_rdy),
        .enq_msg (enq_msg),
        .deq_val (deq_val),
        .deq_rdy (memresp_rdy),
        .deq_msg (deq_msg),
        .count   (q_count)
    );

    // Every accepted request already owns a queue slot, so the delay line never stalls.
    always_ff @(posedge clk) begin
        if (!reset && enq_val) begin
            assert (enq_rdy);
        end
    end

    assign used         = {1'b0, inflight} + {1'b0, q_count};
    assign memreq_rdy   = !reset && (used < (CW+1)'(p_qdepth));
    assign memresp_val  = !reset && deq_val;
    assign memresp_type = deq_msg.kind;
    assign memresp_data = deq_msg.data;

endmodule

// File: tb/tb_plab2_mem_pipelined_resp_mem.sv
// Directed bench for the pipelined memory responder: driver tasks issue requests,
// an expected-response queue is consumed by an independent monitor.
module tb_plab2_mem_pipelined_resp_mem;

    localparam int P_LAT = 2;

    logic        clk;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic        memreq_type;
    logic [31:0] memreq_addr;
    logic [31:0] memreq_data;
    logic        memresp_val;
    logic        memresp_rdy;
    logic        memresp_type;
    logic [31:0] memresp_data;

    logic [32:0] exp_q[$];
    int          acc_q[$];
    int          got_cyc_q[$];
    int          checks;
    int          errors;
    int          cyc;
    int          stalls;
    logic [32:0] held;
    logic        held_valid;

    plab2_mem_pipelined_resp_mem #(
        .p_mem_nwords (256),
        .p_latency    (P_LAT),
        .p_qdepth     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memreq_type  (memreq_type),
        .memreq_addr  (memreq_addr),
        .memreq_data  (memreq_data),
        .memresp_val  (memresp_val),
        .memresp_rdy  (memresp_rdy),
        .memresp_type (memresp_type),
        .memresp_data (memresp_data)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] blk_data(int i);
        return 32'h0A0B_0C00 + 32'(i * 17);
    endfunction

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Response monitor: pops the expected queue on every consumed response and
    // verifies a stalled response does not change while it waits.
    always @(negedge clk) begin
        if (reset || !memresp_val) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("resp_hold", {memresp_type, memresp_data}, held);
            end
            if (memresp_rdy) begin
                held_valid = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {memresp_type, memresp_data}, 33'h0);
                    if ({memresp_type, memresp_data} == 33'h0) begin
                        errors++;
                        $display("FAIL unexpected_resp: got response, required none");
                    end
                end else begin
                    check("resp", {memresp_type, memresp_data}, exp_q.pop_front());
                    got_cyc_q.push_back(cyc);
                end
            end else begin
                held       = {memresp_type, memresp_data};
                held_valid = 1'b1;
            end
        end
    end

    // Driver: hold a request until accepted, then log the expected response.
    task automatic send(input logic t, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] e);
        int w;
        w           = 0;
        memreq_val  = 1'b1;
        memreq_type = t;
        memreq_addr = a;
        memreq_data = d;
        @(negedge clk);
        while (!memreq_rdy && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!memreq_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got memreq_rdy=0, required 1 for addr %h", a);
            memreq_val = 1'b0;
            return;
        end
        if (w != 0) stalls++;
        exp_q.push_back({t, e});
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        memreq_val = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d responses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string name);
        checks++;
        if (got_cyc_q.size() != acc_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d responses, required %0d", name,
                     got_cyc_q.size(), acc_q.size());
        end else begin
            for (int i = 0; i < acc_q.size(); i++) begin
                check({name, "_lat"}, 33'(got_cyc_q[i] - acc_q[i]), 33'(P_LAT));
            end
        end
        acc_q.delete();
        got_cyc_q.delete();
    endtask

    initial begin
        int n_acc;
        checks      = 0;
        errors      = 0;
        stalls      = 0;
        held_valid  = 1'b0;
        reset       = 1'b1;
        memreq_val  = 1'b0;
        memreq_type = 1'b0;
        memreq_addr = 32'h0;
        memreq_data = 32'h0;
        memresp_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_rdy", 33'(memreq_rdy), 33'h0);
        check("reset_resp_val", 33'(memresp_val), 33'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_req_rdy", 33'(memreq_rdy), 33'h1);
        @(posedge clk);
        #1;

        // Write then read back-to-back, fixed latency
        acc_q.delete();
        got_cyc_q.delete();
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        send(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        wait_drain("raw_drain");
        check_latency("raw");

        // Eight back-to-back reads at full throughput
        for (int i = 0; i < 8; i++) send(1'b1, 32'h100 + 32'(4 * i), blk_data(i), 32'h0);
        wait_drain("fill_drain");
        acc_q.delete();
        got_cyc_q.delete();
        stalls = 0;
        for (int i = 0; i < 8; i++) send(1'b0, 32'h100 + 32'(4 * i), 32'h0, blk_data(i));
        wait_drain("stream_drain");
        check("stream_no_stall", 33'(stalls), 33'h0);
        for (int i = 1; i < got_cyc_q.size(); i++) begin
            check("stream_consecutive", 33'(got_cyc_q[i] - got_cyc_q[0]), 33'(i));
        end
        check_latency("stream");

        // Backpressure: only p_qdepth requests may be accepted
        memresp_rdy = 1'b0;
        n_acc       = 0;
        for (int i = 0; i < 6; i++) begin
            memreq_val  = 1'b1;
            memreq_type = 1'b0;
            memreq_addr = 32'h100 + 32'(4 * i);
            @(negedge clk);
            if (memreq_rdy) begin
                n_acc++;
                exp_q.push_back({1'b0, blk_data(i)});
            end
            @(posedge clk);
            #1;
        end
        memreq_val = 1'b0;
        @(negedge clk);
        check("bp_accepted", 33'(n_acc), 33'd4);
        check("bp_req_rdy", 33'(memreq_rdy), 33'h0);
        repeat (3) @(negedge clk);
        check("bp_resp_val", 33'(memresp_val), 33'h1);
        @(posedge clk);
        #1 memresp_rdy = 1'b1;
        wait_drain("bp_drain");
        acc_q.delete();
        got_cyc_q.delete();

        // Address wrap beyond the array depth
        send(1'b1, 32'h0000_0404, 32'h1234_5678, 32'h0);
        send(1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678);
        wait_drain("wrap_drain");
        acc_q.delete();
        got_cyc_q.delete();

        // Reset with requests in flight
        send(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0);
        wait_drain("pre_reset_drain");
        send(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        send(1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_reset_resp_val", 33'(memresp_val), 33'h0);
        check("mid_reset_req_rdy", 33'(memreq_rdy), 33'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flushed_resp_val", 33'(memresp_val), 33'h0);
        end
        @(posedge clk);
        #1;
        send(1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D);
        send(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        wait_drain("post_reset_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plab2_mem_pipelined_resp_mem.md
PLAB2_MEM_PIPELINED_RESP_MEM -- requirements
Module: plab2_mem_pipelined_resp_mem

Interface
REQ-001 SHALL have parameter p_mem_nwords, default 256, memory depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter p_latency, default 2, request-to-response latency in cycles, legal range 1..4.
REQ-003 SHALL have parameter p_qdepth, default 4, response buffer capacity in entries, p_qdepth >= p_latency+1.
REQ-004 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port memreq_val, input, 1 bit, request valid from the processor.
REQ-007 SHALL have port memreq_rdy, output, 1 bit, responder can accept a request.
REQ-008 SHALL have port memreq_type, input, 1 bit, 0 = read, 1 = write.
REQ-009 SHALL have port memreq_addr, input, 32 bits, byte address.
REQ-010 SHALL have port memreq_data, input, 32 bits, write data.
REQ-011 SHALL have port memresp_val, output, 1 bit, response valid.
REQ-012 SHALL have port memresp_rdy, input, 1 bit, processor accepts the response.
REQ-013 SHALL have port memresp_type, output, 1 bit, echo of the request type.
REQ-014 SHALL have port memresp_data, output, 32 bits, read data; 0 for writes.

Function
REQ-015 A request SHALL be accepted in any cycle where memreq_val && memreq_rdy; a response SHALL be consumed in any cycle where memresp_val && memresp_rdy.
REQ-016 Word index SHALL be memreq_addr[log2(p_mem_nwords)+1:2]; addr[1:0] and upper bits ignored, so out-of-range addresses wrap.
REQ-017 A write SHALL update the array at the accept edge; a read SHALL sample the array at the accept edge, so read-after-write in consecutive cycles returns the new data.
REQ-018 An accepted request SHALL pass through a delay line of p_latency-1 stages, then enter a FIFO response queue; memresp_val/type/data SHALL be driven from the queue head.
REQ-019 With an empty queue and no backpressure, a request accepted in cycle c SHALL have memresp_val=1 in cycle c+p_latency.
REQ-020 Responses SHALL be returned strictly in request order; none lost or duplicated.
REQ-021 memreq_rdy SHALL equal (in-flight delay-line entries + queue occupancy) < p_qdepth, with no combinational path from memresp_rdy or memreq_val.
REQ-022 Queue push and pop in the same cycle SHALL leave occupancy unchanged; the credit rule SHALL make overflow impossible, including when full and simultaneous.
REQ-023 With p_qdepth >= p_latency+1 and memresp_rdy held 1, the block SHALL sustain one request per cycle.
REQ-024 While memresp_val=1 and memresp_rdy=0, memresp_type/data SHALL hold stable.
REQ-025 memresp_val=0 SHALL hold whenever the queue is empty, regardless of delay-line contents.

Reset
REQ-026 During reset, memreq_rdy SHALL be 0 and memresp_val SHALL be 0.
REQ-027 Reset SHALL clear delay-line valid bits, queue pointers and occupancy; in-flight requests SHALL be discarded, including when reset asserts mid-operation.
REQ-028 Memory array contents SHALL NOT be reset; data SHALL be preserved across reset.
REQ-029 In the first cycle after reset deasserts, memreq_rdy SHALL be 1.

Structure
REQ-030 Request-type constants (read=0, write=1) and the request/response field widths SHALL live in the shared memory-message package, used by processor control and this block.
REQ-031 The response FIFO SHALL be one sub-module, plab2_mem_resp_queue, with parameterised depth, val/rdy enq/deq ports, and an occupancy count output.

Verification
REQ-032 Bench SHALL cover: write addr 0x0000_0010 data 0xDEAD_BEEF, then read 0x10 -> write response type=1 data=0, then read response data 0xDEAD_BEEF at accept+p_latency.
REQ-033 Bench SHALL cover: 8 back-to-back reads with memresp_rdy=1, p_latency=2, p_qdepth=4 -> memreq_rdy stays 1 and 8 in-order responses on consecutive cycles.
REQ-034 Bench SHALL cover: memresp_rdy=0 with continuous requests -> exactly 4 accepted, memreq_rdy=0 afterwards; on release, 4 responses drain in order with held data stable.
REQ-035 Bench SHALL cover: write 0x0000_0404 data 0x1234_5678 with p_mem_nwords=256, read 0x0000_0004 -> 0x1234_5678 (wrap).
REQ-036 Bench SHALL cover: reset pulse with 2 requests in flight -> no memresp_val afterwards; a pre-reset written word reads back unchanged.
